// File: rtl/cnn_accel_pkg.sv
// cnn_accel_pkg: shared accumulator/bias widths, legal shift window and bias aligner FSM encoding
package cnn_accel_pkg;
  localparam int ACC_BITS  = 48;
  localparam int BIAS_BITS = 16;
  localparam int SHIFT_W   = 5;
  localparam int CNT_W     = 10;
  localparam int MIN_SHIFT = 5;
  localparam int MAX_SHIFT = 25;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/bias_lshift_sat.sv
// bias_lshift_sat: signed left shift of a sign-extended bias with clamp to the signed OUT_BITS range
//   i_data  : sign-extended bias, OUT_BITS wide
//   i_shift : left-shift amount
//   i_zero  : force a zero result (illegal layer shift), never reports saturation
//   o_data  : shifted and clamped result
//   o_sat   : result was clamped
module bias_lshift_sat #(
  parameter int OUT_BITS  = cnn_accel_pkg::ACC_BITS,
  parameter int SHIFT_W   = cnn_accel_pkg::SHIFT_W,
  parameter int MAX_SHIFT = cnn_accel_pkg::MAX_SHIFT
) (
  input  logic [OUT_BITS-1:0] i_data,
  input  logic [SHIFT_W-1:0]  i_shift,
  input  logic                i_zero,
  output logic [OUT_BITS-1:0] o_data,
  output logic                o_sat
);
  import cnn_accel_pkg::*;
  localparam int W = OUT_BITS + MAX_SHIFT;
  logic [W-1:0] w_ext;
  logic [W-1:0] w_sh;
  logic         w_ovf;
  assign w_ext = {{MAX_SHIFT{i_data[OUT_BITS-1]}}, i_data};
  assign w_sh  = w_ext << i_shift;
  // the result fits only if every bit above the OUT_BITS sign position equals that sign
  assign w_ovf = !(&w_sh[W-1:OUT_BITS-1]) && (|w_sh[W-1:OUT_BITS-1]);
  always_comb begin
    o_sat  = !i_zero && w_ovf;
    o_data = i_zero ? '0 :
             !w_ovf ? w_sh[OUT_BITS-1:0] :
             w_sh[W-1] ? {1'b1, {(OUT_BITS-1){1'b0}}} : {1'b0, {(OUT_BITS-1){1'b1}}};
  end
endmodule

// File: rtl/bias_aligner.sv
// bias_aligner: streams layer biases into the accumulator domain, sign-extended and left-shifted by the layer shift
//   clk, rst            : clock, synchronous active-high reset
//   cfg_start           : pulse in IDLE latches cfg_shift/cfg_count and starts a layer
//   cfg_shift/cfg_count : layer shift amount and number of biases (0 allowed)
//   in_valid/in_ready   : bias buffer handshake, in_data signed bias
//   out_valid/out_ready : accumulator preload handshake, out_data aligned signed bias
//   sat_flag            : sticky, some bias of this layer was clamped
//   cfg_err             : sticky, layer shift outside the legal window (outputs forced to 0)
//   done                : one-cycle pulse after the last aligned bias was accepted
module bias_aligner #(
  parameter int IN_BITS   = cnn_accel_pkg::BIAS_BITS,
  parameter int OUT_BITS  = cnn_accel_pkg::ACC_BITS,
  parameter int SHIFT_W   = cnn_accel_pkg::SHIFT_W,
  parameter int CNT_W     = cnn_accel_pkg::CNT_W,
  parameter int MIN_SHIFT = cnn_accel_pkg::MIN_SHIFT,
  parameter int MAX_SHIFT = cnn_accel_pkg::MAX_SHIFT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [SHIFT_W-1:0]  cfg_shift,
  input  logic [CNT_W-1:0]    cfg_count,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic                sat_flag,
  output logic                cfg_err,
  output logic                done
);
  import cnn_accel_pkg::*;
  state_t              r_state;
  logic [SHIFT_W-1:0]  r_shift;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_in_cnt;
  logic [CNT_W-1:0]    r_out_cnt;
  logic                r_bad;
  logic                r_s1_v;
  logic [OUT_BITS-1:0] r_s1_d;
  logic [OUT_BITS-1:0] w_res;
  logic [CNT_W-1:0]    w_in_nxt;
  logic [CNT_W-1:0]    w_out_nxt;
  logic                w_sat;
  logic                w_s2_adv;
  logic                w_s1_adv;
  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_bad;
  // S2 frees up when empty or being consumed; S1 may then refill in the same cycle
  assign w_s2_adv   = !out_valid || out_ready;
  assign w_s1_adv   = !r_s1_v || w_s2_adv;
  assign in_ready   = (r_state == ST_RUN) && (r_in_cnt < r_count) && w_s1_adv;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_bad      = (int'(cfg_shift) < MIN_SHIFT) || (int'(cfg_shift) > MAX_SHIFT);
  assign w_in_nxt   = r_in_cnt + CNT_W'(w_in_fire);
  assign w_out_nxt  = r_out_cnt + CNT_W'(w_out_fire && (r_out_cnt != r_count));
  bias_lshift_sat #(
    .OUT_BITS (OUT_BITS),
    .SHIFT_W  (SHIFT_W),
    .MAX_SHIFT(MAX_SHIFT)
  ) u_lshift_sat (
    .i_data (r_s1_d),
    .i_shift(r_shift),
    .i_zero (r_bad),
    .o_data (w_res),
    .o_sat  (w_sat)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_count   <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_bad     <= 1'b0;
      r_s1_v    <= 1'b0;
      r_s1_d    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
      cfg_err   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      r_in_cnt  <= w_in_nxt;
      r_out_cnt <= w_out_nxt;
      if (w_s1_adv) begin
        r_s1_v <= w_in_fire;
        if (w_in_fire) r_s1_d <= {{(OUT_BITS-IN_BITS){in_data[IN_BITS-1]}}, in_data};
      end
      if (w_s2_adv) begin
        out_valid <= r_s1_v;
        if (r_s1_v) begin
          out_data <= w_res;
          sat_flag <= sat_flag | w_sat;
        end
      end
      case (r_state)
        ST_IDLE: if (cfg_start) begin
          r_shift   <= cfg_shift;
          r_count   <= cfg_count;
          r_bad     <= w_bad;
          cfg_err   <= w_bad;
          sat_flag  <= 1'b0;
          r_in_cnt  <= '0;
          r_out_cnt <= '0;
          r_state   <= (cfg_count == '0) ? ST_IDLE : ST_RUN;
          done      <= (cfg_count == '0);
        end
        ST_RUN: if (w_in_nxt == r_count) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_out_nxt == r_count) begin
          r_state <= ST_IDLE;
          done    <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bias_aligner.sv
// tb_bias_aligner: random and directed layers on a 48-bit and a 24-bit aligner against a queue-based model
module tb_bias_aligner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [4:0]  cfg_shift = '0;
  logic [9:0]  cfg_count = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, sat_flag, cfg_err, done;
  logic [47:0] out_data;
  logic        n_in_ready, n_out_valid, n_sat, n_err, n_done;
  logic [23:0] n_out_data;
  int          checks = 0;
  int          errors = 0;
  int          ndone = 0;
  longint      cyc = 0;
  typedef struct {
    longint t;
    longint w;
    longint n;
    bit     sw;
    bit     sn;
  } item_t;
  item_t       q[$];
  longint      got[$];
  longint      gotn[$];
  logic [15:0] feed[$];
  bit          act = 0, done_e = 0, sat_w = 0, sat_n = 0, err_e = 0;
  int          m_shift = 0, m_count = 0, m_in = 0, m_out = 0;
  bit [3:0]    pat = 4'b1001;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bias_aligner u_dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_shift(cfg_shift), .cfg_count(cfg_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_flag(sat_flag), .cfg_err(cfg_err), .done(done)
  );
  bias_aligner #(.OUT_BITS(24)) u_nar (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_shift(cfg_shift), .cfg_count(cfg_count),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .sat_flag(n_sat), .cfg_err(n_err), .done(n_done)
  );

  function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", nm, a, e, cyc);
    end
  endfunction

  function automatic longint raw(logic [15:0] d, int sh);
    longint v;
    v = $signed(d);
    return (sh < 5 || sh > 25) ? 64'sd0 : v <<< sh;
  endfunction

  function automatic longint clampv(longint v, int ob);
    longint hi;
    hi = (longint'(1) <<< (ob - 1)) - 1;
    return v > hi ? hi : (v < -hi - 1) ? -hi - 1 : v;
  endfunction

  // Model: items in flight are a queue; an item is visible one edge after acceptance once it heads the queue,
  // and the input side may accept while fewer than two items are in flight or the head is being consumed.
  always @(negedge clk) begin : mon
    bit     ev, ir, idle;
    longint r;
    if (rst) begin
      q.delete();
      act = 0; done_e = 0; sat_w = 0; sat_n = 0; err_e = 0;
    end else begin
      ev = q.size() > 0 && cyc >= q[0].t + 1;
      if (ev) begin
        sat_w |= q[0].sw;
        sat_n |= q[0].sn;
      end
      ir = act && m_in < m_count && (q.size() < 2 || out_ready);
      chk("in_ready", in_ready, ir);
      chk("n_in_ready", n_in_ready, ir);
      chk("out_valid", out_valid, ev);
      chk("n_out_valid", n_out_valid, ev);
      chk("done", done, done_e);
      chk("n_done", n_done, done_e);
      chk("sat_flag", sat_flag, sat_w);
      chk("n_sat_flag", n_sat, sat_n);
      chk("cfg_err", cfg_err, err_e);
      chk("n_cfg_err", n_err, err_e);
      if (done) ndone++;
      idle = !act;
      done_e = 0;
      if (ev) begin
        chk("out_data", $signed(out_data), q[0].w);
        chk("n_out_data", $signed(n_out_data), q[0].n);
        if (out_ready) begin
          got.push_back($signed(out_data));
          gotn.push_back($signed(n_out_data));
          void'(q.pop_front());
          m_out++;
          if (m_out == m_count) begin
            act = 0;
            done_e = 1;
          end
        end
      end
      if (ir && in_valid) begin
        r = raw(in_data, m_shift);
        q.push_back('{cyc + 1, clampv(r, 48), clampv(r, 24), clampv(r, 48) != r, clampv(r, 24) != r});
        m_in++;
      end
      if (idle && cfg_start) begin
        m_shift = int'(cfg_shift);
        m_count = int'(cfg_count);
        m_in = 0; m_out = 0;
        err_e = m_shift < 5 || m_shift > 25;
        sat_w = 0; sat_n = 0;
        act = m_count != 0;
        done_e = m_count == 0;
      end
    end
  end

  task automatic step(int pv, int pr, int k);
    bit acc;
    in_valid = feed.size() > 0 ? 1'b1 : ($urandom_range(99) < pv);
    in_data = feed.size() > 0 ? feed[0] : 16'($urandom);
    out_ready = pr < 0 ? pat[k % 4] : ($urandom_range(99) < pr);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc && feed.size() > 0) void'(feed.pop_front());
  endtask

  task automatic run_layer(int sh, int cnt, int pv, int pr, bit poke);
    bit seen;
    got.delete(); gotn.delete(); ndone = 0;
    cfg_shift = 5'(sh); cfg_count = 10'(cnt); cfg_start = 1; in_valid = 0; out_ready = 1;
    @(posedge clk);
    #1;
    cfg_start = 0;
    seen = done;
    for (int k = 0; k < 3000 && !seen; k++) begin
      cfg_start = poke && ($urandom_range(7) == 0);
      if (cfg_start) cfg_shift = 5'($urandom);
      step(pv, pr, k);
      seen = done;
    end
    cfg_start = 0; in_valid = 0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL layer_timeout done=%0b want 1 within 3000 cycles", seen);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, want finish before 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_err", cfg_err, 0);
    // shift 8, three biases, no backpressure
    feed = '{16'h0001, 16'hFFFF, 16'h7FFF};
    run_layer(8, 3, 100, 100, 0);
    chk("t1_n", got.size(), 3);
    chk("t1_o0", got[0], 64'h100);
    chk("t1_o1", got[1], -64'sd256);
    chk("t1_o2", got[2], 64'h7FFF00);
    chk("t1_done", ndone, 1);
    // out_ready 1,0,0,1 repeating
    feed = '{16'h0011, 16'h8000, 16'h0022, 16'hFFF0};
    run_layer(5, 4, 100, -1, 0);
    chk("t2_n", got.size(), 4);
    chk("t2_o0", got[0], 64'h220);
    chk("t2_o1", got[1], -64'sd1048576);
    chk("t2_o3", got[3], -64'sd512);
    // illegal shift: zeros, full count, sticky error cleared by next legal layer
    feed = '{16'h1234, 16'h0042};
    run_layer(3, 2, 100, 100, 0);
    chk("t3_err", cfg_err, 1);
    chk("t3_n", got.size(), 2);
    chk("t3_o0", got[0], 0);
    chk("t3_o1", got[1], 0);
    chk("t3_done", ndone, 1);
    run_layer(10, 1, 100, 100, 0);
    chk("t3_err_clr", cfg_err, 0);
    // saturation on the 24-bit instance only
    feed = '{16'h4000, 16'h8000, 16'h0000};
    run_layer(25, 3, 100, 100, 0);
    chk("t4_n0", gotn[0], 64'h7FFFFF);
    chk("t4_n1", gotn[1], -64'sd8388608);
    chk("t4_nsat", n_sat, 1);
    chk("t4_w0", got[0], 64'sd549755813888);
    chk("t4_w1", got[1], -64'sd1099511627776);
    chk("t4_wsat", sat_flag, 0);
    // empty layer
    run_layer(12, 0, 100, 100, 0);
    chk("t5_done", ndone, 1);
    chk("t5_n", got.size(), 0);
    // reset with two items in flight
    ndone = 0;
    cfg_shift = 6; cfg_count = 5; cfg_start = 1;
    @(posedge clk);
    #1;
    cfg_start = 0; in_valid = 1; out_ready = 0; in_data = 16'h0123;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("t6_full", out_valid, 1);
    in_valid = 0; rst = 1;
    @(posedge clk);
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_done", done, 0);
    rst = 0; out_ready = 1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("t6_no_done", ndone, 0);
    // random layers with ignored mid-layer cfg_start pulses
    for (int i = 0; i < 24; i++) begin
      run_layer($urandom_range(9) == 0 ? int'($urandom_range(31)) : int'($urandom_range(25, 5)),
                int'($urandom_range(12)), int'($urandom_range(100, 30)), int'($urandom_range(100, 20)), 1);
      chk("rand_done", ndone, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
